// File: rtl/button_bank.sv
// button_bank: N-channel push-button front end.
// Each channel runs independently: a 2-flop synchroniser, then an
// IDLE -> LOCK -> HELD -> REL_LOCK state machine. The machine emits
// single-cycle press, release and long-press pulses, a debounced level,
// and a wrapping press counter.
// `release` is a reserved word in SystemVerilog, so the release pulse
// port is named `rel`.
// dbg_state carries each channel's state: channel i is at [2*i +: 2],
// encoded 0=IDLE, 1=LOCK, 2=HELD, 3=REL_LOCK.
// Optional feature: define BUTTON_BANK_AUTOREPEAT_EN to enable autorepeat.
// While a button stays held after long_press, press pulses repeat every
// REPEAT_CYCLES cycles.
module button_bank #(
   parameter int N_BTN           = 2,
   parameter int CNT_W           = 6,
   parameter int ACTIVE_LOW      = 1,
   parameter int DEBOUNCE_CYCLES = 2_700_000,
   parameter int LONG_CYCLES     = 27_000_000,
   parameter int REPEAT_CYCLES   = 5_400_000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_BTN-1:0]       btn,
   output logic [N_BTN-1:0]       pressed,
   output logic [N_BTN-1:0]       press,
   output logic [N_BTN-1:0]       rel,
   output logic [N_BTN-1:0]       long_press,
   output logic [N_BTN*CNT_W-1:0] count,
   output logic [2*N_BTN-1:0]     dbg_state
);

   localparam int TW = $clog2(LONG_CYCLES + 1);
   localparam logic [TW-1:0] DEB_LAST  = TW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] LONG_LAST = TW'(LONG_CYCLES - 1);
   localparam logic [TW-1:0] LONG_MAX  = TW'(LONG_CYCLES);
   // Raw pin level that means "not pressed"; the synchroniser resets to it.
   localparam logic IDLE_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

`ifdef BUTTON_BANK_AUTOREPEAT_EN
   localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
`endif

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_LOCK     = 2'd1,
      ST_HELD     = 2'd2,
      ST_REL_LOCK = 2'd3
   } state_t;

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      logic          s1, s2, act;
      state_t        st;
      logic [TW-1:0] tmr, tmr_inc;
      logic [CNT_W-1:0] cnt;
      logic          pressed_r, press_r, rel_r, long_r;
`ifdef BUTTON_BANK_AUTOREPEAT_EN
      logic          rep_on;
      logic [RW-1:0] rep_tmr;
`endif

      // Two-flop synchroniser for the asynchronous pin.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            s1 <= IDLE_LVL;
            s2 <= IDLE_LVL;
         end else begin
            s1 <= btn[i];
            s2 <= s1;
         end
      end

      assign act     = s2 ^ IDLE_LVL;
      assign tmr_inc = (tmr == LONG_MAX) ? tmr : tmr + 1'b1;

      // Channel FSM. Event pulses are cleared each cycle unless re-asserted.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            st        <= ST_IDLE;
            tmr       <= '0;
            cnt       <= '0;
            pressed_r <= 1'b0;
            press_r   <= 1'b0;
            rel_r     <= 1'b0;
            long_r    <= 1'b0;
`ifdef BUTTON_BANK_AUTOREPEAT_EN
            rep_on    <= 1'b0;
            rep_tmr   <= '0;
`endif
         end else begin
            press_r <= 1'b0;
            rel_r   <= 1'b0;
            long_r  <= 1'b0;
            case (st)
               ST_IDLE: begin
                  if (act) begin
                     st        <= ST_LOCK;
                     tmr       <= '0;
                     press_r   <= 1'b1;
                     cnt       <= cnt + 1'b1;
                     pressed_r <= 1'b1;
                  end
               end
               ST_LOCK: begin
                  tmr <= tmr_inc;
                  if (act && tmr == LONG_LAST) long_r <= 1'b1;
                  if (tmr == DEB_LAST) st <= ST_HELD;
               end
               ST_HELD: begin
                  tmr <= tmr_inc;
                  // Release wins over a long-press that lands on the same cycle.
                  if (!act) begin
                     rel_r     <= 1'b1;
                     pressed_r <= 1'b0;
                     st        <= ST_REL_LOCK;
                     tmr       <= '0;
`ifdef BUTTON_BANK_AUTOREPEAT_EN
                     rep_on    <= 1'b0;
                     rep_tmr   <= '0;
`endif
                  end else if (tmr == LONG_LAST) begin
                     long_r <= 1'b1;
`ifdef BUTTON_BANK_AUTOREPEAT_EN
                     rep_on  <= 1'b1;
                     rep_tmr <= '0;
`endif
                  end
`ifdef BUTTON_BANK_AUTOREPEAT_EN
                  else if (rep_on) begin
                     if (rep_tmr == REP_LAST) begin
                        press_r <= 1'b1;
                        cnt     <= cnt + 1'b1;
                        rep_tmr <= '0;
                     end else begin
                        rep_tmr <= rep_tmr + 1'b1;
                     end
                  end
`endif
               end
               ST_REL_LOCK: begin
                  tmr <= tmr_inc;
                  if (tmr == DEB_LAST) st <= ST_IDLE;
               end
               default: st <= ST_IDLE;
            endcase
         end
      end

      assign pressed[i]                = pressed_r;
      assign press[i]                  = press_r;
      assign rel[i]                    = rel_r;
      assign long_press[i]             = long_r;
      assign count[i*CNT_W +: CNT_W]   = cnt;
      assign dbg_state[2*i +: 2]       = st;
   end

endmodule

// File: tb/tb_button_bank.sv
// tb_button_bank: randomized and directed stimulus for button_bank.
// The reference model is event-based. It tracks, per channel, whether the
// button is held, the cycle of the last accepted press and the cycle of the
// last accepted release. From those it derives when lockouts end and when
// long_press is due. The model pushes one expected output word per clock
// edge; a monitor pops each word on the falling edge and compares it.
module tb_button_bank;

   localparam int N_BTN = 2;
   localparam int CNT_W = 4;
   localparam int DEB   = 4;
   localparam int LONG  = 16;
   localparam int REP   = 3;
   localparam int VW    = 4 * N_BTN + N_BTN * CNT_W;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic [N_BTN-1:0] btn = 2'b11;
   logic [N_BTN-1:0] pressed, press, rel, long_press;
   logic [N_BTN*CNT_W-1:0] count;
   logic [2*N_BTN-1:0] dbg_state;

   always #5 clk = ~clk;

   button_bank #(
      .N_BTN(N_BTN), .CNT_W(CNT_W), .ACTIVE_LOW(1),
      .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn(btn),
      .pressed(pressed), .press(press), .rel(rel), .long_press(long_press),
      .count(count), .dbg_state(dbg_state)
   );

   // ---------------- scoreboard state ----------------
   logic [VW-1:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   // ---------------- reference model ----------------
   int cyc = 0;
   bit held   [N_BTN];
   int t_press[N_BTN];
   int t_rel  [N_BTN];
   int cnt    [N_BTN];
   bit a1     [N_BTN];
   bit a2     [N_BTN];

   initial begin
      for (int c = 0; c < N_BTN; c++) begin
         held[c] = 0; t_press[c] = 0; t_rel[c] = -1000; cnt[c] = 0;
         a1[c] = 0; a2[c] = 0;
      end
   end

   task automatic model_step();
      logic [N_BTN-1:0] e_p, e_rl, e_lp, e_held;
      logic [N_BTN*CNT_W-1:0] e_cnt;
      bit act;
      int k;
      cyc++;
      k = cyc;
      e_p = '0; e_rl = '0; e_lp = '0;
      for (int c = 0; c < N_BTN; c++) begin
         // The state machine sees the pin value from two edges earlier.
         act = a2[c];
         a2[c] = rst_n ? a1[c] : 1'b0;
         a1[c] = rst_n ? ~btn[c] : 1'b0;
         if (!rst_n) begin
            held[c] = 0; t_rel[c] = -1000; cnt[c] = 0;
         end else if (!held[c]) begin
            if (k >= t_rel[c] + DEB + 1 && act) begin
               held[c] = 1; t_press[c] = k;
               cnt[c] = (cnt[c] + 1) % (1 << CNT_W);
               e_p[c] = 1'b1;
            end
         end else if (k >= t_press[c] + DEB + 1) begin
            if (!act) begin
               held[c] = 0; t_rel[c] = k; e_rl[c] = 1'b1;
            end else begin
               if (k == t_press[c] + LONG) e_lp[c] = 1'b1;
`ifdef BUTTON_BANK_AUTOREPEAT_EN
               if (k > t_press[c] + LONG && ((k - t_press[c] - LONG) % REP) == 0) begin
                  e_p[c] = 1'b1;
                  cnt[c] = (cnt[c] + 1) % (1 << CNT_W);
               end
`endif
            end
         end
         e_held[c] = held[c];
         e_cnt[c*CNT_W +: CNT_W] = CNT_W'(cnt[c]);
      end
      exp_q.push_back({e_held, e_p, e_rl, e_lp, e_cnt});
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // ---------------- monitor ----------------
   initial forever begin
      logic [VW-1:0] got, want;
      @(negedge clk);
      if (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         got  = {pressed, press, rel, long_press, count};
         n_vec++;
         if (got !== want) begin
            n_err++;
            $display("FAIL cycle %0d outputs {pressed,press,rel,long,count}: got %b want %b",
                     cyc, got, want);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [N_BTN-1:0] b, input int n);
      btn = b;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset(input logic [N_BTN-1:0] b, input int n);
      rst_n = 1'b0;
      drive(b, n);
      rst_n = 1'b1;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d vectors", n_vec);
      n_err++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [N_BTN-1:0] rb;
      // Reset held for two cycles with both buttons released.
      do_reset(2'b11, 2);
      drive(2'b11, 4);
      // Clean press and release on ch0.
      drive(2'b10, 10);
      drive(2'b11, 15);
      // Bounce on ch0, then a steady press.
      drive(2'b10, 1);
      drive(2'b11, 1);
      drive(2'b10, 1);
      drive(2'b10, 12);
      drive(2'b11, 15);
      // Long hold on ch1.
      drive(2'b01, 30);
      drive(2'b11, 15);
      // Seventeen clean presses on ch0 wrap the counter.
      for (int i = 0; i < 17; i++) begin
         drive(2'b10, 8);
         drive(2'b11, 8);
      end
      // Reset while ch0 is held, with ch0 still low when reset lifts.
      drive(2'b10, 8);
      do_reset(2'b10, 2);
      drive(2'b10, 10);
      drive(2'b11, 15);
      // Random segments with bounces, long holds and occasional resets.
      for (int i = 0; i < 80; i++) begin
         rb = N_BTN'($urandom_range(0, 3));
         if ($urandom_range(0, 19) == 0)
            do_reset(rb, $urandom_range(1, 2));
         else if ($urandom_range(0, 3) == 0)
            drive(rb, $urandom_range(1, 3));
         else
            drive(rb, $urandom_range(4, 24));
      end
      drive(2'b11, 30);
      @(negedge clk);
      @(negedge clk);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expected words left, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
